// File: rtl/spi_sensor_responder.sv
// SPI responder (CPOL=0) for the sensor link: takes a command word on MOSI, then returns a response word on MISO.
// The SPI pins are oversampled in the clk domain. The response word comes from a one-deep ready/valid holding register.
module spi_sensor_responder #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_active,
    output logic                  frame_err,
    output logic                  underrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CMD, RSP, WAIT_END} state_t;

    logic sck_p0, sck_p1, sck_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic mosi_p0, mosi_p1;

    // Stage p0/p1: two-flop synchronisers; p2: delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_p0  <= 1'b0;
            sck_p1  <= 1'b0;
            sck_p2  <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sck_p0  <= sck;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            cs_p0   <= cs_n;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    assign sck_rise = sck_p1 & ~sck_p2;
    assign sck_fall = ~sck_p1 & sck_p2;
    assign cs_rise  = cs_p1 & ~cs_p2;
    assign cs_fall  = ~cs_p1 & cs_p2;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-2:0] cmd_shift;
    logic [DATA_WIDTH-1:0] rsp_shift;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  hold_full;

    assign tx_ready = ~hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            cmd_shift    <= '0;
            rsp_shift    <= '0;
            hold_reg     <= '0;
            hold_full    <= 1'b0;
            miso         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_active <= 1'b0;
            frame_err    <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            underrun  <= 1'b0;

            // A load coinciding with an underrunning frame start survives for the next frame
            if (tx_valid && !hold_full) begin
                hold_reg  <= tx_data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        state        <= CMD;
                        frame_active <= 1'b1;
                        bit_cnt      <= '0;
                        if (hold_full) begin
                            rsp_shift <= hold_reg;
                            hold_full <= 1'b0;
                        end else begin
                            rsp_shift <= '0;
                            underrun  <= 1'b1;
                        end
                    end
                end
                CMD: begin
                    if (cs_rise) begin
                        state        <= IDLE;
                        frame_active <= 1'b0;
                        frame_err    <= 1'b1;
                        miso         <= 1'b0;
                    end else if (sck_rise) begin
                        cmd_shift <= {cmd_shift[DATA_WIDTH-3:0], mosi_p1};
                        if (bit_cnt == LAST_BIT) begin
                            rx_data  <= {cmd_shift, mosi_p1};
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= RSP;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                RSP: begin
                    if (cs_rise) begin
                        state        <= IDLE;
                        frame_active <= 1'b0;
                        frame_err    <= 1'b1;
                        miso         <= 1'b0;
                    end else begin
                        if (sck_fall) begin
                            miso      <= rsp_shift[DATA_WIDTH-1];
                            rsp_shift <= {rsp_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (sck_rise) begin
                            if (bit_cnt == LAST_BIT) begin
                                state <= WAIT_END;
                                miso  <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                WAIT_END: begin
                    miso <= 1'b0;
                    if (cs_rise) begin
                        state        <= IDLE;
                        frame_active <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    frame_active <= 1'b0;
                    miso         <= 1'b0;
                end
            endcase
        end
    end

endmodule
